slow_sched: RTL and testbench
=============================

// Module: slow_sched
// PURPOSE
//  Slow-mode scheduler for the accelerator bus. Consumes the per-device slow-enable flags
//  and 4-bit hold timeout from the slow-configuration register, watches decoded bus accesses,
//  and drives Slow (drop to motherboard speed) with a programmable post-access hold window.
//  Sits between the address decode / bus-cycle logic and the clock-switch logic.
// PARAMETERS
//  TICK_DIV  64  CLK cycles per timeout tick (>=2); hold window = SlowTimeout*TICK_DIV cycles
//  STAT_W    16  width of the slow-entry statistics counter (SLOW_STATS_EN only)
// PORTS
//  CLK            in   1  system clock; all logic on posedge CLK
//  POR            in   1  reset, synchronous, active-high
//  BACT           in   1  bus cycle active
//  IACKSel        in   1  current access is interrupt acknowledge
//  VIASel         in   1  current access targets VIA
//  IWMSel         in   1  current access targets IWM
//  SCCSel         in   1  current access targets SCC
//  SCSISel        in   1  current access targets SCSI
//  SndSel         in   1  current access targets sound buffer
//  ForceSlow      in   1  external slow request (treated as a hit while high, ignores BACT)
//  SlowIACK..SlowSnd in 1 each  per-device slow enables from configuration register
//  SlowClockGate  in   1  clock-gate enable from configuration register
//  SlowTimeout    in   4  hold timeout; 0 = no hold, 1..E = ticks, F = sticky
//  Slow           out  1  registered slow-mode request
//  ClockGateEn    out  1  registered; = Slow & SlowClockGate, same cycle as Slow
//  SlowCount      out  STAT_W  slow-entry count (SLOW_STATS_EN only)
// BEHAVIOUR
//  - Hit (comb) = ForceSlow | BACT & ((IACKSel&SlowIACK)|(VIASel&SlowVIA)|(IWMSel&SlowIWM)
//    |(SCCSel&SlowSCC)|(SCSISel&SlowSCSI)|(SndSel&SlowSnd)).
//  - POR=1: state IDLE, Slow=0, ClockGateEn=0, Cnt=0, Pre=0, SlowCount=0. POR overrides all.
//  - States IDLE, ACTIVE, HOLD, STICKY. Slow=1 in ACTIVE/HOLD/STICKY, 0 in IDLE; Slow and
//    ClockGateEn are registered: high on the edge that enters a non-IDLE state.
//  - IDLE: Hit -> ACTIVE (Slow high 1 cycle after Hit sampled).
//  - ACTIVE: Hit -> stay. !Hit: SlowTimeout=0 -> IDLE; =F -> STICKY;
//    else -> HOLD, Cnt<=SlowTimeout, Pre<=TICK_DIV-1.
//  - HOLD: Hit -> ACTIVE (Cnt/Pre discarded). Else Pre decrements each cycle; at Pre=0:
//    Pre<=TICK_DIV-1, Cnt<=Cnt-1; if Cnt=1 and Pre=0 -> IDLE. HOLD lasts exactly
//    SlowTimeout*TICK_DIV cycles; Slow falls on the following edge.
//  - STICKY: Hit -> ACTIVE; !Hit and SlowTimeout!=F -> IDLE; else stay.
//  - SlowTimeout sampled only on ACTIVE->HOLD/STICKY; changes during HOLD do not affect Cnt.
//  - ClockGateEn tracks SlowClockGate each cycle while Slow=1; 0 whenever Slow=0.
//  - Hit and !Hit alternating each cycle: ACTIVE<->HOLD, Slow never drops.
//  - Cnt 4-bit, never underflows (exit at Cnt=1); Pre log2(TICK_DIV) bits, reload wraps.
// CONFIGURATION
//  SLOW_STATS_EN defined: SlowCount increments on every IDLE->ACTIVE transition, saturates
//    at all-ones, cleared only by POR.
//  SLOW_STATS_EN undefined: SlowCount port absent; no counter logic.
// TESTING
//  - POR=1 3 cycles with Hit forced -> Slow=0, ClockGateEn=0, state IDLE throughout.
//  - SlowVIA=1, SlowTimeout=2, TICK_DIV=64, VIA access BACT 4 cycles -> Slow high 1 cycle
//    after BACT, stays 4+128 cycles of state ACTIVE+HOLD, falls on next edge.
//  - SlowVIA=0, VIA access -> Slow stays 0; same with ForceSlow=1 -> Slow=1, SlowTimeout=0
//    -> Slow drops 1 cycle after ForceSlow falls.
//  - SlowTimeout=F, SCC hit then idle 1000 cycles -> Slow=1; write SlowTimeout=3 -> Slow=0
//    next edge; SlowClockGate=1 -> ClockGateEn mirrors Slow.
//  - HOLD with Cnt=1, Pre=5, new IWM hit -> returns ACTIVE, Slow never deasserts; POR
//    mid-HOLD -> Slow=0 next edge.
//  - SLOW_STATS_EN, STAT_W=4: 20 separate slow entries -> SlowCount=4'hF (saturated).

Source files
------------

// File: rtl/slow_sched.sv
// slow_sched -- slow-mode scheduler for the accelerator bus.
//
// Watches decoded bus accesses against the per-device slow enables. It raises
// Slow (drop to motherboard speed) on a hit, then holds it for a programmable
// window once the hits stop.
// Hold window = SlowTimeout * TICK_DIV cycles. SlowTimeout of 0 means no hold.
// SlowTimeout of F holds until the timeout register is rewritten.
//
// Optional feature macro: SLOW_STATS_EN. When it is defined, the SlowCount port
// is present and counts IDLE->ACTIVE entries, saturating at all-ones.
//
// Ports:
//   CLK, POR                       clock, synchronous active-high reset
//   BACT                           bus cycle active
//   IACKSel..SndSel                decoded access target selects
//   ForceSlow                      external slow request (hit regardless of BACT)
//   SlowIACK..SlowSnd              per-device slow enables
//   SlowClockGate                  clock-gate enable
//   SlowTimeout[3:0]               hold timeout in ticks
//   Slow                           registered slow-mode request
//   ClockGateEn                    registered Slow & SlowClockGate
//   SlowCount[STAT_W-1:0]          slow-entry count (SLOW_STATS_EN only)
module slow_sched #(
  parameter int TICK_DIV = 64,
  parameter int STAT_W   = 16
) (
  input  logic              CLK,
  input  logic              POR,
  input  logic              BACT,
  input  logic              IACKSel,
  input  logic              VIASel,
  input  logic              IWMSel,
  input  logic              SCCSel,
  input  logic              SCSISel,
  input  logic              SndSel,
  input  logic              ForceSlow,
  input  logic              SlowIACK,
  input  logic              SlowVIA,
  input  logic              SlowIWM,
  input  logic              SlowSCC,
  input  logic              SlowSCSI,
  input  logic              SlowSnd,
  input  logic              SlowClockGate,
  input  logic [3:0]        SlowTimeout,
`ifdef SLOW_STATS_EN
  output logic [STAT_W-1:0] SlowCount,
`endif
  output logic              Slow,
  output logic              ClockGateEn
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, STICKY} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;
  logic             hit;

  assign hit = ForceSlow | (BACT & ((IACKSel & SlowIACK) | (VIASel & SlowVIA) |
                                    (IWMSel & SlowIWM) | (SCCSel & SlowSCC) |
                                    (SCSISel & SlowSCSI) | (SndSel & SlowSnd)));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pre_nxt   = pre;
    case (state)
      IDLE:   if (hit) state_nxt = ACTIVE;
      ACTIVE: if (!hit) begin
        if (SlowTimeout == 4'h0)      state_nxt = IDLE;
        else if (SlowTimeout == 4'hF) state_nxt = STICKY;
        else begin
          // Timeout is captured here only; later rewrites don't stretch the hold.
          state_nxt = HOLD;
          cnt_nxt   = SlowTimeout;
          pre_nxt   = PRE_MAX;
        end
      end
      HOLD: begin
        if (hit) state_nxt = ACTIVE;
        else if (pre == '0) begin
          // Leaving at cnt==1 keeps cnt from ever wrapping below zero.
          if (cnt == 4'd1) state_nxt = IDLE;
          cnt_nxt = cnt - 4'd1;
          pre_nxt = PRE_MAX;
        end else begin
          pre_nxt = pre - PRE_W'(1);
        end
      end
      STICKY: begin
        if (hit)                      state_nxt = ACTIVE;
        else if (SlowTimeout != 4'hF) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs follow the next state so Slow rises on the edge that leaves IDLE.
  always_ff @(posedge CLK) begin
    if (POR) begin
      state       <= IDLE;
      cnt         <= '0;
      pre         <= '0;
      Slow        <= 1'b0;
      ClockGateEn <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pre         <= pre_nxt;
      Slow        <= (state_nxt != IDLE);
      ClockGateEn <= (state_nxt != IDLE) & SlowClockGate;
    end
  end

`ifdef SLOW_STATS_EN
  always_ff @(posedge CLK) begin
    if (POR) SlowCount <= '0;
    else if (state == IDLE && state_nxt == ACTIVE && SlowCount != '1)
      SlowCount <= SlowCount + STAT_W'(1);
  end
`endif

endmodule

// File: tb/tb_slow_sched.sv
// tb_slow_sched -- self-checking bench for slow_sched.
// A behavioural model tracks Slow as "on", plus a remaining-hold cycle count
// and a sticky flag. The model is stepped from the inputs sampled at each
// rising edge. DUT outputs are compared against it on the falling edge.
module tb_slow_sched;
  localparam int TD = 64;
  localparam int SW = 4;

  logic       CLK = 1'b0;
  logic       POR, BACT, ForceSlow, SlowClockGate;
  logic [5:0] sel, en;   // {Snd, SCSI, SCC, IWM, VIA, IACK}
  logic [3:0] to;
  logic       Slow, ClockGateEn;
`ifdef SLOW_STATS_EN
  logic [SW-1:0] SlowCount;
`endif

  always #5 CLK = ~CLK;

  slow_sched #(.TICK_DIV(TD), .STAT_W(SW)) dut (
    .CLK(CLK), .POR(POR), .BACT(BACT),
    .IACKSel(sel[0]), .VIASel(sel[1]), .IWMSel(sel[2]),
    .SCCSel(sel[3]), .SCSISel(sel[4]), .SndSel(sel[5]),
    .ForceSlow(ForceSlow),
    .SlowIACK(en[0]), .SlowVIA(en[1]), .SlowIWM(en[2]),
    .SlowSCC(en[3]), .SlowSCSI(en[4]), .SlowSnd(en[5]),
    .SlowClockGate(SlowClockGate), .SlowTimeout(to),
`ifdef SLOW_STATS_EN
    .SlowCount(SlowCount),
`endif
    .Slow(Slow), .ClockGateEn(ClockGateEn)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit m_on, m_act, m_sticky, m_cge;
  int m_hold, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit_now();
    return ForceSlow | (BACT & (|(sel & en)));
  endfunction

  task automatic model_edge();
    bit h;
    h = hit_now();
    if (POR) begin
      m_on = 0; m_act = 0; m_sticky = 0; m_hold = 0; m_cnt = 0;
    end else if (h) begin
      if (!m_on && m_cnt < (1 << SW) - 1) m_cnt++;
      m_on = 1; m_act = 1; m_sticky = 0; m_hold = 0;
    end else if (m_act) begin
      m_act = 0;
      if (to == 4'h0)      m_on = 0;
      else if (to == 4'hF) m_sticky = 1;
      else                 m_hold = int'(to) * TD;
    end else if (m_sticky) begin
      if (to != 4'hF) begin m_on = 0; m_sticky = 0; end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) m_on = 0;
    end
    m_cge = m_on & SlowClockGate;
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      chk("slow", 32'(Slow), 32'(m_on));
      chk("cge", 32'(ClockGateEn), 32'(m_cge));
`ifdef SLOW_STATS_EN
      chk("count", 32'(SlowCount), 32'(m_cnt));
`endif
    end
  endtask

  task automatic bus_idle();
    BACT = 0; sel = '0; ForceSlow = 0;
  endtask

  int hi_cnt;

  initial begin
    // Reset with a hit held on: outputs must stay low.
    POR = 1; BACT = 1; sel = 6'h3F; en = 6'h3F; ForceSlow = 1;
    SlowClockGate = 1; to = 4'h2;
    step(3);
    chk("por_slow", 32'(Slow), 32'd0);

    // VIA access of 4 cycles with a 2-tick hold: 4+128 high cycles.
    POR = 0; bus_idle(); en = 6'b000010; SlowClockGate = 0;
    step(2);
    BACT = 1; sel = 6'b000010;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin step(); hi_cnt += int'(Slow); end
    bus_idle();
    for (int i = 0; i < 140; i++) begin step(); hi_cnt += int'(Slow); end
    chk("via_len", 32'(hi_cnt), 32'd132);

    // Disabled device: no slow. ForceSlow with no hold drops one cycle later.
    en = 6'b0; to = 4'h0; BACT = 1; sel = 6'b000010;
    step(3);
    chk("via_off", 32'(Slow), 32'd0);
    ForceSlow = 1; step(3);
    ForceSlow = 0; bus_idle(); step(1);
    chk("force_drop", 32'(Slow), 32'd0);
    step(2);

    // Sticky: SCC hit, long idle, then rewriting the timeout releases Slow.
    en = 6'b001000; to = 4'hF; SlowClockGate = 1;
    BACT = 1; sel = 6'b001000; step(2);
    bus_idle(); step(1000);
    chk("sticky", 32'(Slow), 32'd1);
    chk("sticky_cge", 32'(ClockGateEn), 32'd1);
    to = 4'h3; step(1);
    chk("sticky_rel", 32'(Slow), 32'd0);
    step(2);

    // Last tick of a 1-tick hold, re-hit near its end: Slow must not dip.
    en = 6'b000100; to = 4'h1;
    BACT = 1; sel = 6'b000100; step(1);
    bus_idle(); step(59);
    BACT = 1; sel = 6'b000100; step(1);
    bus_idle(); step(30);
    POR = 1; step(1);
    chk("por_hold", 32'(Slow), 32'd0);
    POR = 0; step(3);

    // Many separate entries; the 4-bit count saturates.
    en = 6'h3F; to = 4'h0;
    for (int i = 0; i < 20; i++) begin
      BACT = 1; sel = 6'b100000; step(1);
      bus_idle(); step(2);
    end

    // Alternating hit / no-hit with a hold configured: Slow stays up.
    to = 4'h2;
    for (int i = 0; i < 20; i++) begin
      BACT = i[0]; sel = 6'b010000; step(1);
    end
    bus_idle(); step(5);

    // Random traffic with occasional config changes and rare resets.
    for (int i = 0; i < 4000; i++) begin
      BACT = ($urandom_range(0, 29) == 0);
      sel = 6'(1 << $urandom_range(0, 5));
      ForceSlow = ($urandom_range(0, 199) == 0);
      POR = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 49) == 0) en = 6'($urandom);
      if ($urandom_range(0, 99) == 0) to = 4'($urandom_range(0, 4) == 0 ? 15 : $urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) SlowClockGate = 1'($urandom);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
